// File: rtl/sint_serial_cmp_pkg.sv
// Shared types and the per-beat relation update for the bit-serial signed comparator.
// Pure combinational helper: no state, no arithmetic, no carry chain.
package sint_serial_pkg;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        LT = 2'b01,
        GT = 2'b10
    } rel_t;

    typedef enum logic {
        RECV = 1'b0,
        DONE = 1'b1
    } state_t;

    // Higher bits override lower ones; on the sign bit a set bit means negative.
    function automatic rel_t rel_step(rel_t rel, logic a, logic b, logic is_sign);
        rel_t r;
        r = rel;
        if (a != b) begin
            if (is_sign) r = a ? LT : GT;
            else         r = a ? GT : LT;
        end
        return r;
    endfunction

endpackage

// File: rtl/sint_serial_cmp_if.sv
// Bit-pair input stream plus registered compare result, both valid/ready handshaked.
// master drives the operand bits and consumes results; slave is the comparator.
interface sint_serial_cmp_if;
    logic in_valid;
    logic in_ready;
    logic I0_bit;
    logic I1_bit;
    logic out_valid;
    logic out_ready;
    logic O_sle;
    logic O_sge;
    logic O_eq;

    modport master (
        output in_valid, I0_bit, I1_bit, out_ready,
        input  in_ready, out_valid, O_sle, O_sge, O_eq
    );

    modport slave (
        input  in_valid, I0_bit, I1_bit, out_ready,
        output in_ready, out_valid, O_sle, O_sge, O_eq
    );
endinterface

// File: rtl/sint_serial_cmp.sv
// Bit-serial signed compare, LSB-first; result registered on the sign-bit beat (width accept cycles).
// in_ready drops while a result is held; result holds until out_ready, then input reopens next cycle.
module sint_serial_cmp
    import sint_serial_pkg::*;
#(
    parameter int width = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    sint_serial_cmp_if.slave   bus
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    rel_t            rel_q, rel_d;
    logic            vld_q, vld_d;
    logic            sle_q, sle_d;
    logic            sge_q, sge_d;
    logic            eq_q, eq_d;

    logic            accept;
    logic            is_sign;
    logic            release_res;
    rel_t            rel_fin;

    assign accept      = bus.in_valid && (state_q == RECV);
    assign is_sign     = (cnt_q == CW'(width - 1));
    assign release_res = vld_q && bus.out_ready;
    assign rel_fin     = rel_step(rel_q, bus.I0_bit, bus.I1_bit, is_sign);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RECV;
            cnt_q   <= '0;
            rel_q   <= EQ;
            vld_q   <= 1'b0;
            sle_q   <= 1'b0;
            sge_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            vld_q   <= vld_d;
            sle_q   <= sle_d;
            sge_q   <= sge_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV:    if (accept && is_sign) state_d = DONE;
            DONE:    if (release_res)       state_d = RECV;
            default: state_d = RECV;
        endcase
    end

    // Counter, running relation and result registers; results only move on the sign beat.
    always_comb begin
        cnt_d = cnt_q;
        rel_d = rel_q;
        vld_d = vld_q;
        sle_d = sle_q;
        sge_d = sge_q;
        eq_d  = eq_q;
        if (accept) begin
            rel_d = rel_fin;
            if (is_sign) begin
                cnt_d = '0;
                vld_d = 1'b1;
                sle_d = (rel_fin != GT);
                sge_d = (rel_fin != LT);
                eq_d  = (rel_fin == EQ);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == DONE && release_res) begin
            vld_d = 1'b0;
            rel_d = EQ;
        end
    end

    assign bus.in_ready  = (state_q == RECV);
    assign bus.out_valid = vld_q;
    assign bus.O_sle     = sle_q;
    assign bus.O_sge     = sge_q;
    assign bus.O_eq      = eq_q;

endmodule
